calc_display: RTL and testbench

CALC_DISPLAY -- requirements
Module: calc_display

---
 rtl/calc_display.sv | 256 +++++++++++++++++++++++++
 tb/tb_calc_display.sv | 345 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/calc_display.sv
// calc_display
// Takes the 8-bit unsigned result from the calculator stage and shows it on a
// three-digit multiplexed seven-segment display.
// - A sequential double-dabble converter turns the binary value into BCD in
//   8 clock steps. The digits currently on display stay frozen until the
//   conversion has finished.
// - A free-running prescaler rotates the one-hot digit select.
// Build option: define LEADING_ZERO_BLANK_EN to blank leading zero digits.
// The ones digit is never blanked.
module calc_display #(
  parameter int unsigned SCAN_DIV = 1000
) (
  input  logic       clock,
  input  logic       Reset,
  input  logic [7:0] NumIn,
  output logic [6:0] Segments,
  output logic [2:0] DigitSel,
  output logic       Busy
);

  // Last prescaler count before it wraps and the digit select advances.
  localparam logic [15:0] SCAN_LAST = 16'(SCAN_DIV - 1);
  // Step index of the eighth and final double-dabble step.
  localparam logic [3:0]  LAST_STEP = 4'd7;

  typedef enum logic [0:0] {
    IDLE    = 1'b0,
    CONVERT = 1'b1
  } state_t;

  state_t      state;
  state_t      state_next;

  // Value most recently accepted for display. A change on NumIn is detected
  // by comparing against this register.
  logic [7:0]  shown;

  // Committed BCD digits. Only these registers feed the segment decoder.
  logic [3:0]  hund;
  logic [3:0]  tens;
  logic [3:0]  ones;

  // Double-dabble working storage.
  logic [3:0]  work_hund;
  logic [3:0]  work_tens;
  logic [3:0]  work_ones;
  logic [7:0]  shift;
  logic [3:0]  step;

  // One combinational double-dabble step.
  logic [3:0]  adj_hund;
  logic [3:0]  adj_tens;
  logic [3:0]  adj_ones;
  logic [19:0] dabble_vec;
  logic [19:0] shifted;

  logic        start;
  logic        last_step;

  // Scan prescaler.
  logic [15:0] presc;

  // Segment selection.
  logic [3:0]  digit;
  logic        blank;

  // Double-dabble correction: a nibble of 5 or more gets 3 added, so that the
  // following left shift carries correctly into the next decimal digit.
  function automatic logic [3:0] dabble_adjust(input logic [3:0] nib);
    logic [3:0] res;
    if (nib >= 4'd5) begin
      res = nib + 4'd3;
    end else begin
      res = nib;
    end
    return res;
  endfunction

  // BCD digit to segment pattern; bit0 = a ... bit6 = g, active high.
  function automatic logic [6:0] seg_decode(input logic [3:0] dig);
    logic [6:0] seg;
    case (dig)
      4'd0:    seg = 7'b0111111;
      4'd1:    seg = 7'b0000110;
      4'd2:    seg = 7'b1011011;
      4'd3:    seg = 7'b1001111;
      4'd4:    seg = 7'b1100110;
      4'd5:    seg = 7'b1101101;
      4'd6:    seg = 7'b1111101;
      4'd7:    seg = 7'b0000111;
      4'd8:    seg = 7'b1111111;
      4'd9:    seg = 7'b1101111;
      default: seg = 7'b0000000;
    endcase
    return seg;
  endfunction

  // Conversion start (changed input while idle) and final-step detection.
  always_comb begin
    start     = (state == IDLE) && (NumIn != shown);
    last_step = (state == CONVERT) && (step == LAST_STEP);
  end

  // FSM state register.
  always_ff @(posedge clock) begin
    if (Reset) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // FSM next-state logic.
  always_comb begin
    state_next = state;
    case (state)
      IDLE: begin
        if (start) begin
          state_next = CONVERT;
        end else begin
          state_next = IDLE;
        end
      end
      CONVERT: begin
        if (last_step) begin
          state_next = IDLE;
        end else begin
          state_next = CONVERT;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // FSM outputs: Busy is high for every cycle spent in CONVERT.
  always_comb begin
    Busy = 1'b0;
    if (state == CONVERT) begin
      Busy = 1'b1;
    end else begin
      Busy = 1'b0;
    end
  end

  // One double-dabble step: correct every work nibble, then shift the
  // {work, shift} chain left by one bit.
  always_comb begin
    adj_hund   = dabble_adjust(work_hund);
    adj_tens   = dabble_adjust(work_tens);
    adj_ones   = dabble_adjust(work_ones);
    dabble_vec = {adj_hund, adj_tens, adj_ones, shift};
    shifted    = dabble_vec << 1;
  end

  // Converter datapath.
  // - A capture loads the input and clears the work area.
  // - Each CONVERT edge applies one step.
  // - The eighth step commits the finished digits, so no partial result is
  //   ever visible on the display.
  always_ff @(posedge clock) begin
    if (Reset) begin
      shown     <= 8'd0;
      shift     <= 8'd0;
      work_hund <= 4'd0;
      work_tens <= 4'd0;
      work_ones <= 4'd0;
      step      <= 4'd0;
      hund      <= 4'd0;
      tens      <= 4'd0;
      ones      <= 4'd0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            shown     <= NumIn;
            shift     <= NumIn;
            work_hund <= 4'd0;
            work_tens <= 4'd0;
            work_ones <= 4'd0;
            step      <= 4'd0;
          end else begin
            step      <= 4'd0;
          end
        end
        CONVERT: begin
          {work_hund, work_tens, work_ones, shift} <= shifted;
          step <= step + 4'd1;
          if (last_step) begin
            hund <= shifted[19:16];
            tens <= shifted[15:12];
            ones <= shifted[11:8];
          end else begin
            hund <= hund;
          end
        end
        default: begin
          step <= 4'd0;
        end
      endcase
    end
  end

  // Digit scan. The prescaler counts 0..SCAN_DIV-1. On each wrap the select
  // rotates ones -> tens -> hundreds -> ones. The scan runs independently of
  // the converter.
  always_ff @(posedge clock) begin
    if (Reset) begin
      presc    <= 16'd0;
      DigitSel <= 3'b001;
    end else if (presc == SCAN_LAST) begin
      presc    <= 16'd0;
      DigitSel <= {DigitSel[1:0], DigitSel[2]};
    end else begin
      presc    <= presc + 16'd1;
    end
  end

  // Pick the selected committed digit and decode it to segments. Optional
  // leading-zero blanking applies to the hundreds and tens digits only.
  always_comb begin
    digit = 4'd0;
    blank = 1'b0;
    case (DigitSel)
      3'b001: begin
        digit = ones;
        blank = 1'b0;
      end
      3'b010: begin
        digit = tens;
`ifdef LEADING_ZERO_BLANK_EN
        blank = (hund == 4'd0) && (tens == 4'd0);
`else
        blank = 1'b0;
`endif
      end
      3'b100: begin
        digit = hund;
`ifdef LEADING_ZERO_BLANK_EN
        blank = (hund == 4'd0);
`else
        blank = 1'b0;
`endif
      end
      default: begin
        digit = 4'hF;
        blank = 1'b1;
      end
    endcase
    if (blank) begin
      Segments = 7'b0000000;
    end else begin
      Segments = seg_decode(digit);
    end
  end

endmodule

// File: tb/tb_calc_display.sv
// Self-checking bench for calc_display (SCAN_DIV = 4).
// Expected values come from a cycle-level behavioural model: a remaining-busy
// countdown, the integer value on display, and a tick count since reset.
// Digits are derived with / and %. Segment patterns come from the digit table.
module tb_calc_display;

  localparam int SCAN = 4;

  logic       clock;
  logic       Reset;
  logic [7:0] NumIn;
  logic [6:0] Segments;
  logic [2:0] DigitSel;
  logic       Busy;

  int n_checks;
  int n_fail;

  // Behavioural model state.
  int m_shown;
  int m_pending;
  int m_disp;
  int m_left;
  int m_tick;

  calc_display #(.SCAN_DIV(SCAN)) dut (
    .clock    (clock),
    .Reset    (Reset),
    .NumIn    (NumIn),
    .Segments (Segments),
    .DigitSel (DigitSel),
    .Busy     (Busy)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Segment pattern for one decimal digit.
  function automatic logic [6:0] seg_of(input int d);
    case (d)
      0:       return 7'b0111111;
      1:       return 7'b0000110;
      2:       return 7'b1011011;
      3:       return 7'b1001111;
      4:       return 7'b1100110;
      5:       return 7'b1101101;
      6:       return 7'b1111101;
      7:       return 7'b0000111;
      8:       return 7'b1111111;
      9:       return 7'b1101111;
      default: return 7'b0000000;
    endcase
  endfunction

  // Digit select the model expects: position (ticks / SCAN) mod 3.
  function automatic logic [2:0] exp_sel();
    case ((m_tick / SCAN) % 3)
      0:       return 3'b001;
      1:       return 3'b010;
      default: return 3'b100;
    endcase
  endfunction

  // Segments expected for an integer value shown at the given digit position.
  function automatic logic [6:0] exp_seg(input int value, input logic [2:0] sel);
    case (sel)
      3'b001: return seg_of(value % 10);
      3'b010: begin
`ifdef LEADING_ZERO_BLANK_EN
        if (value < 10) return 7'b0000000;
`endif
        return seg_of((value / 10) % 10);
      end
      3'b100: begin
`ifdef LEADING_ZERO_BLANK_EN
        if (value < 100) return 7'b0000000;
`endif
        return seg_of(value / 100);
      end
      default: return 7'b0000000;
    endcase
  endfunction

  // Advance one clock edge, update the model with the inputs seen at that
  // edge, then settle 1 time unit past the edge.
  task automatic tick();
    logic       r;
    logic [7:0] n;
    r = Reset;
    n = NumIn;
    @(posedge clock);
    if (r) begin
      m_shown = 0;
      m_disp  = 0;
      m_left  = 0;
      m_tick  = 0;
    end else begin
      m_tick++;
      if (m_left > 0) begin
        m_left--;
        if (m_left == 0) m_disp = m_pending;
      end else if (int'(n) != m_shown) begin
        m_shown   = int'(n);
        m_pending = int'(n);
        m_left    = 8;
      end
    end
    #1;
  endtask

  task automatic test_reset();
    Reset = 1'b1;
    NumIn = 8'd0;
    tick();
    Reset = 1'b0;
    n_checks++;
    if (Busy !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_busy: got %b expected 0", Busy);
    end
    n_checks++;
    if (DigitSel !== 3'b001) begin
      n_fail++;
      $display("FAIL reset_sel: got %b expected 001", DigitSel);
    end
    n_checks++;
    if (Segments !== 7'b0111111) begin
      n_fail++;
      $display("FAIL reset_ones_seg: got %b expected 0111111", Segments);
    end
    for (int i = 0; i < 20; i++) begin
      tick();
      n_checks++;
      if (Busy !== 1'b0) begin
        n_fail++;
        $display("FAIL idle_zero_busy: cycle %0d got %b expected 0", i, Busy);
      end
      if (exp_sel() == 3'b100) begin
        n_checks++;
`ifdef LEADING_ZERO_BLANK_EN
        if (Segments !== 7'b0000000) begin
          n_fail++;
          $display("FAIL zero_hund_seg: got %b expected 0000000", Segments);
        end
`else
        if (Segments !== 7'b0111111) begin
          n_fail++;
          $display("FAIL zero_hund_seg: got %b expected 0111111", Segments);
        end
`endif
      end
    end
  endtask

  task automatic test_scan();
    logic [2:0] want;
    Reset = 1'b1;
    tick();
    Reset = 1'b0;
    for (int i = 0; i < 13; i++) begin
      case ((i / 4) % 3)
        0:       want = 3'b001;
        1:       want = 3'b010;
        default: want = 3'b100;
      endcase
      n_checks++;
      if (DigitSel !== want) begin
        n_fail++;
        $display("FAIL scan_sel: cycle %0d got %b expected %b", i, DigitSel, want);
      end
      tick();
    end
  endtask

  task automatic test_convert_255();
    NumIn = 8'd255;
    tick();
    for (int j = 0; j < 8; j++) begin
      n_checks++;
      if (Busy !== 1'b1) begin
        n_fail++;
        $display("FAIL conv255_busy: k+%0d got %b expected 1", j, Busy);
      end
      n_checks++;
      if (Segments !== exp_seg(0, exp_sel())) begin
        n_fail++;
        $display("FAIL conv255_old_digits: k+%0d got %b expected %b", j, Segments, exp_seg(0, exp_sel()));
      end
      tick();
    end
    n_checks++;
    if (Busy !== 1'b0) begin
      n_fail++;
      $display("FAIL conv255_done: got %b expected 0", Busy);
    end
    for (int i = 0; i < 3 * SCAN; i++) begin
      n_checks++;
      if (Segments !== exp_seg(255, exp_sel())) begin
        n_fail++;
        $display("FAIL conv255_digits: sel %b got %b expected %b", exp_sel(), Segments, exp_seg(255, exp_sel()));
      end
      tick();
    end
  endtask

  task automatic test_midchange();
    logic exp_busy;
    int   exp_val;
    NumIn = 8'd123;
    tick();
    for (int e = 1; e <= 17; e++) begin
      if (e == 3) NumIn = 8'd45;
      tick();
      exp_busy = (e <= 7) || (e >= 9 && e <= 16);
      exp_val  = (e < 8) ? 255 : ((e < 17) ? 123 : 45);
      n_checks++;
      if (Busy !== exp_busy) begin
        n_fail++;
        $display("FAIL mid_busy: k+%0d got %b expected %b", e, Busy, exp_busy);
      end
      n_checks++;
      if (Segments !== exp_seg(exp_val, exp_sel())) begin
        n_fail++;
        $display("FAIL mid_digits: k+%0d got %b expected %b", e, Segments, exp_seg(exp_val, exp_sel()));
      end
    end
    for (int i = 0; i < 3 * SCAN; i++) begin
      tick();
      n_checks++;
      if (Segments !== exp_seg(45, exp_sel())) begin
        n_fail++;
        $display("FAIL mid_final: sel %b got %b expected %b", exp_sel(), Segments, exp_seg(45, exp_sel()));
      end
    end
  endtask

  task automatic test_reset_abort();
    NumIn = 8'd200;
    tick();
    for (int e = 1; e <= 3; e++) begin
      tick();
      n_checks++;
      if (Busy !== 1'b1) begin
        n_fail++;
        $display("FAIL abort_busy_pre: k+%0d got %b expected 1", e, Busy);
      end
    end
    Reset = 1'b1;
    NumIn = 8'd0;
    tick();
    Reset = 1'b0;
    n_checks++;
    if (Busy !== 1'b0) begin
      n_fail++;
      $display("FAIL abort_busy: got %b expected 0", Busy);
    end
    n_checks++;
    if (DigitSel !== 3'b001) begin
      n_fail++;
      $display("FAIL abort_sel: got %b expected 001", DigitSel);
    end
    for (int i = 0; i < 3 * SCAN; i++) begin
      n_checks++;
      if (DigitSel !== exp_sel() || Segments !== exp_seg(0, exp_sel()) || Busy !== 1'b0) begin
        n_fail++;
        $display("FAIL abort_after: sel %b seg %b busy %b expected sel %b seg %b busy 0",
                 DigitSel, Segments, Busy, exp_sel(), exp_seg(0, exp_sel()));
      end
      tick();
    end
  endtask

  task automatic test_blank();
    logic [6:0] want;
    NumIn = 8'd7;
    for (int i = 0; i < 9; i++) tick();
    for (int i = 0; i < 3 * SCAN; i++) begin
      case (exp_sel())
        3'b001:  want = 7'b0000111;
`ifdef LEADING_ZERO_BLANK_EN
        default: want = 7'b0000000;
`else
        default: want = 7'b0111111;
`endif
      endcase
      n_checks++;
      if (Segments !== want) begin
        n_fail++;
        $display("FAIL blank_7: sel %b got %b expected %b", exp_sel(), Segments, want);
      end
      tick();
    end
    NumIn = 8'd100;
    for (int i = 0; i < 9; i++) tick();
    for (int i = 0; i < 3 * SCAN; i++) begin
      case (exp_sel())
        3'b100:  want = 7'b0000110;
        default: want = 7'b0111111;
      endcase
      n_checks++;
      if (Segments !== want) begin
        n_fail++;
        $display("FAIL blank_100: sel %b got %b expected %b", exp_sel(), Segments, want);
      end
      tick();
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 800; i++) begin
      Reset = ($urandom_range(0, 59) == 0);
      if ($urandom_range(0, 5) == 0) NumIn = 8'($urandom_range(0, 255));
      tick();
      Reset = 1'b0;
      n_checks++;
      if (Busy !== (m_left > 0) || DigitSel !== exp_sel() || Segments !== exp_seg(m_disp, exp_sel())) begin
        n_fail++;
        $display("FAIL random: cycle %0d busy %b sel %b seg %b expected busy %b sel %b seg %b",
                 i, Busy, DigitSel, Segments, (m_left > 0), exp_sel(), exp_seg(m_disp, exp_sel()));
      end
    end
  endtask

  initial begin
    n_checks  = 0;
    n_fail    = 0;
    m_shown   = 0;
    m_pending = 0;
    m_disp    = 0;
    m_left    = 0;
    m_tick    = 0;
    Reset     = 1'b1;
    NumIn     = 8'd0;
    test_reset();
    test_scan();
    test_convert_255();
    test_midchange();
    test_reset_abort();
    test_blank();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
